// File: rtl/picorv32_avl_pkg.sv
// Shared types and constants for the PicoRV32 to Avalon-MM line bridge.
package picorv32_avl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_DATA,
    RESP
  } state_e;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned STRB_W        = WORD_W / 8;
  localparam int unsigned BURST_LEN_DEF = 4;
  localparam int unsigned OFF_W         = $clog2(BURST_LEN_DEF);
  localparam int unsigned WR_BURSTCOUNT = 1;

  // Offset width for a given line length; never below 1 bit.
  function automatic int unsigned off_bits(input int unsigned burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/avl_line_buf.sv
// One-line read buffer: byte-strobed write port, combinational read port.
module avl_line_buf
  import picorv32_avl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Data storage carries no reset; validity is tracked by the bridge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/picorv32_avl_line_bridge.sv
// PicoRV32 native memory port to DDR3 EMIF Avalon-MM bridge with a one-line
// read buffer filled by bursts; writes are single-beat write-through.
module picorv32_avl_line_bridge
  import picorv32_avl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned BURST_W   = 3
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                init_done,
  input  logic                flush,
  input  logic                cpu_valid,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic [3:0]          cpu_wstrb,
  output logic                cpu_ready,
  output logic [31:0]         cpu_rdata,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [BURST_W-1:0]  avl_burstcount,
  output logic                avl_beginbursttransfer,
  output logic                avl_read,
  output logic                avl_write,
  output logic [31:0]         avl_writedata,
  output logic [3:0]          avl_byteenable,
  input  logic                avl_waitrequest_n,
  input  logic [31:0]         avl_readdata,
  input  logic                avl_readdatavalid
);

  localparam int unsigned         LOFF_W    = off_bits(BURST_LEN);
  localparam logic [LOFF_W-1:0]   LAST_BEAT = LOFF_W'(BURST_LEN - 1);

  logic [ADDR_W-1:0] wa, tag;
  logic [LOFF_W-1:0] off;
  logic              rd_req, line_hit, beat_in;
  logic              unused_addr_bits;

  state_e              state_q, state_d;
  logic                line_valid_q, line_valid_d;
  logic [ADDR_W-1:0]   line_tag_q, line_tag_d;
  logic [LOFF_W-1:0]   beat_q, beat_d;
  logic                flush_pend_q, flush_pend_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0]   avl_address_q, avl_address_d;
  logic [BURST_W-1:0]  avl_burstcount_q, avl_burstcount_d;
  logic                avl_begin_q, avl_begin_d;
  logic                avl_read_q, avl_read_d;
  logic                avl_write_q, avl_write_d;
  logic [31:0]         avl_writedata_q, avl_writedata_d;
  logic [3:0]          avl_byteenable_q, avl_byteenable_d;

  logic                lb_we;
  logic [LOFF_W-1:0]   lb_widx;
  logic [STRB_W-1:0]   lb_wstrb;
  logic [WORD_W-1:0]   lb_wdata, lb_rdata;

  assign wa               = cpu_addr[ADDR_W+1:2];
  assign tag              = wa & ~ADDR_W'(BURST_LEN - 1);
  assign off              = wa[LOFF_W-1:0];
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
  assign rd_req           = (cpu_wstrb == '0);
  // A same-cycle flush turns a would-be hit into a miss.
  assign line_hit         = line_valid_q && (line_tag_q == tag) && !flush;
  assign beat_in          = avl_readdatavalid && ((state_q == RD_CMD) || (state_q == RD_DATA));

  avl_line_buf #(
    .DEPTH (BURST_LEN),
    .IDX_W (LOFF_W)
  ) u_line_buf (
    .clk   (clk_clk),
    .we    (lb_we),
    .widx  (lb_widx),
    .wstrb (lb_wstrb),
    .wdata (lb_wdata),
    .ridx  (off),
    .rdata (lb_rdata)
  );

  // Next-state, buffer write port and registered output computation.
  always_comb begin
    state_d          = state_q;
    line_valid_d     = line_valid_q;
    line_tag_d       = line_tag_q;
    beat_d           = beat_q;
    flush_pend_d     = flush_pend_q;
    cpu_ready_d      = 1'b0;
    cpu_rdata_d      = '0;
    avl_address_d    = avl_address_q;
    avl_burstcount_d = avl_burstcount_q;
    avl_begin_d      = 1'b0;
    avl_read_d       = avl_read_q;
    avl_write_d      = avl_write_q;
    avl_writedata_d  = avl_writedata_q;
    avl_byteenable_d = avl_byteenable_q;
    lb_we            = 1'b0;
    lb_widx          = beat_q;
    lb_wstrb         = '1;
    lb_wdata         = avl_readdata;

    if (flush && (state_q != RD_CMD) && (state_q != RD_DATA)) line_valid_d = 1'b0;

    if (beat_in) begin
      lb_we  = 1'b1;
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (rd_req && line_hit) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = lb_rdata;
            state_d     = RESP;
          end else if (init_done) begin
            avl_begin_d = 1'b1;
            if (rd_req) begin
              state_d          = RD_CMD;
              avl_read_d       = 1'b1;
              avl_address_d    = tag;
              avl_burstcount_d = BURST_W'(BURST_LEN);
              beat_d           = '0;
              flush_pend_d     = 1'b0;
              line_valid_d     = 1'b0;
            end else begin
              state_d          = WR;
              avl_write_d      = 1'b1;
              avl_address_d    = wa;
              avl_burstcount_d = BURST_W'(WR_BURSTCOUNT);
              avl_writedata_d  = cpu_wdata;
              avl_byteenable_d = cpu_wstrb;
              if (line_hit) begin
                lb_we    = 1'b1;
                lb_widx  = off;
                lb_wstrb = cpu_wstrb;
                lb_wdata = cpu_wdata;
              end
            end
          end
        end
      end
      WR: begin
        if (avl_waitrequest_n) begin
          avl_write_d      = 1'b0;
          avl_address_d    = '0;
          avl_burstcount_d = '0;
          avl_writedata_d  = '0;
          avl_byteenable_d = '0;
          cpu_ready_d      = 1'b1;
          state_d          = RESP;
        end
      end
      RD_CMD: begin
        if (flush) flush_pend_d = 1'b1;
        if (avl_waitrequest_n) begin
          avl_read_d       = 1'b0;
          avl_address_d    = '0;
          avl_burstcount_d = '0;
          state_d          = RD_DATA;
        end
      end
      RD_DATA: begin
        if (flush) flush_pend_d = 1'b1;
        if (beat_in && (beat_q == LAST_BEAT)) begin
          line_tag_d   = tag;
          line_valid_d = !(flush_pend_q || flush);
          cpu_ready_d  = 1'b1;
          // The last beat lands in the buffer this edge, so forward it directly.
          cpu_rdata_d  = (off == LAST_BEAT) ? avl_readdata : lb_rdata;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q          <= IDLE;
      line_valid_q     <= 1'b0;
      line_tag_q       <= '0;
      beat_q           <= '0;
      flush_pend_q     <= 1'b0;
      cpu_ready_q      <= 1'b0;
      cpu_rdata_q      <= '0;
      avl_address_q    <= '0;
      avl_burstcount_q <= '0;
      avl_begin_q      <= 1'b0;
      avl_read_q       <= 1'b0;
      avl_write_q      <= 1'b0;
      avl_writedata_q  <= '0;
      avl_byteenable_q <= '0;
    end else begin
      state_q          <= state_d;
      line_valid_q     <= line_valid_d;
      line_tag_q       <= line_tag_d;
      beat_q           <= beat_d;
      flush_pend_q     <= flush_pend_d;
      cpu_ready_q      <= cpu_ready_d;
      cpu_rdata_q      <= cpu_rdata_d;
      avl_address_q    <= avl_address_d;
      avl_burstcount_q <= avl_burstcount_d;
      avl_begin_q      <= avl_begin_d;
      avl_read_q       <= avl_read_d;
      avl_write_q      <= avl_write_d;
      avl_writedata_q  <= avl_writedata_d;
      avl_byteenable_q <= avl_byteenable_d;
    end
  end

  assign cpu_ready              = cpu_ready_q;
  assign cpu_rdata              = cpu_rdata_q;
  assign avl_address            = avl_address_q;
  assign avl_burstcount         = avl_burstcount_q;
  assign avl_beginbursttransfer = avl_begin_q;
  assign avl_read               = avl_read_q;
  assign avl_write              = avl_write_q;
  assign avl_writedata          = avl_writedata_q;
  assign avl_byteenable         = avl_byteenable_q;

endmodule

// File: tb/tb_picorv32_avl_line_bridge.sv
// Scoreboard bench: a memory-level model predicts CPU responses and Avalon
// commands; an Avalon slave/monitor process checks them as they appear.
module tb_picorv32_avl_line_bridge;

  localparam int ADDR_W    = 21;
  localparam int BURST_LEN = 4;
  localparam int BURST_W   = 3;

  logic                clk_clk = 1'b0;
  logic                reset_reset, init_done, flush, cpu_valid;
  logic [31:0]         cpu_addr, cpu_wdata;
  logic [3:0]          cpu_wstrb;
  logic                cpu_ready;
  logic [31:0]         cpu_rdata;
  logic [ADDR_W-1:0]   avl_address;
  logic [BURST_W-1:0]  avl_burstcount;
  logic                avl_beginbursttransfer, avl_read, avl_write;
  logic [31:0]         avl_writedata;
  logic [3:0]          avl_byteenable;
  logic                avl_waitrequest_n;
  logic [31:0]         avl_readdata;
  logic                avl_readdatavalid;

  always #5 clk_clk = ~clk_clk;

  picorv32_avl_line_bridge #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .BURST_W   (BURST_W)
  ) dut (
    .clk_clk                (clk_clk),
    .reset_reset            (reset_reset),
    .init_done              (init_done),
    .flush                  (flush),
    .cpu_valid              (cpu_valid),
    .cpu_addr               (cpu_addr),
    .cpu_wdata              (cpu_wdata),
    .cpu_wstrb              (cpu_wstrb),
    .cpu_ready              (cpu_ready),
    .cpu_rdata              (cpu_rdata),
    .avl_address            (avl_address),
    .avl_burstcount         (avl_burstcount),
    .avl_beginbursttransfer (avl_beginbursttransfer),
    .avl_read               (avl_read),
    .avl_write              (avl_write),
    .avl_writedata          (avl_writedata),
    .avl_byteenable         (avl_byteenable),
    .avl_waitrequest_n      (avl_waitrequest_n),
    .avl_readdata           (avl_readdata),
    .avl_readdatavalid      (avl_readdatavalid)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] rdata;
    int          n_cmd;
    logic [20:0] addr;
    logic [2:0]  bc;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          held;
  } exp_t;

  typedef struct {
    bit          is_wr;
    logic [20:0] addr;
    logic [2:0]  bc;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          held;
  } cmd_t;

  exp_t exp_q[$];
  cmd_t cmd_log[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] ddr     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  bit          m_valid = 0;
  logic [20:0] m_tag   = '0;

  int          cyc_cnt = 0;
  int          wait_n = -1;
  bit          beat_stall = 0;
  int          pending = 0;
  int          bidx = 0;

  always @(posedge clk_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seed_word(input int unsigned a);
    logic [31:0] t;
    t = a * 32'h9E37_79B1;
    return t ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ddr_rd(input int unsigned a);
    return ddr.exists(a) ? ddr[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  // Avalon slave plus scoreboard monitor; samples on the falling edge.
  initial begin : bus
    int          hold_cnt;
    bit          prev_cmd, prev_ready, init_prev, wrn;
    logic [29:0] snap;
    logic [31:0] snap_wd;
    logic [20:0] rbase;
    int          last_beat_cyc;
    cmd_t        c;
    exp_t        e;
    hold_cnt = 0; prev_cmd = 0; prev_ready = 0; init_prev = 0;
    snap = '0; snap_wd = '0; rbase = '0; last_beat_cyc = 0;
    avl_waitrequest_n = 1'b0;
    avl_readdata      = '0;
    avl_readdatavalid = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (reset_reset) begin
        pending = 0; bidx = 0; prev_cmd = 0; prev_ready = 0; hold_cnt = 0;
        cmd_log.delete();
        avl_readdatavalid = 1'b0;
        avl_waitrequest_n = 1'b0;
        init_prev = init_done;
      end else begin
        if (avl_read || avl_write) begin
          if (prev_cmd) begin
            chk("cmd_stable", {avl_address, avl_byteenable, avl_burstcount, avl_read, avl_write}, snap);
            chk("cmd_stable_wdata", avl_writedata, snap_wd);
            chk("begin_only_first", avl_beginbursttransfer, 0);
          end else begin
            chk("begin_first", avl_beginbursttransfer, 1);
            chk("init_gate", init_prev, 1);
            hold_cnt = 0;
          end
          snap    = {avl_address, avl_byteenable, avl_burstcount, avl_read, avl_write};
          snap_wd = avl_writedata;
          wrn = (wait_n >= 0) ? (hold_cnt >= wait_n) : ($urandom_range(0, 2) != 0);
          avl_waitrequest_n = wrn;
          if (wrn) begin
            c.is_wr = avl_write; c.addr = avl_address; c.bc = avl_burstcount;
            c.be = avl_byteenable; c.wdata = avl_writedata; c.held = hold_cnt + 1;
            cmd_log.push_back(c);
            if (avl_write) begin
              ddr[int'(avl_address)] = merge(ddr_rd(int'(avl_address)), avl_writedata, avl_byteenable);
            end else begin
              pending = BURST_LEN; bidx = 0; rbase = avl_address;
            end
            prev_cmd = 0;
          end else begin
            prev_cmd = 1;
            hold_cnt++;
          end
        end else begin
          if (prev_cmd) chk("cmd_dropped", avl_read | avl_write, 1);
          prev_cmd = 0;
          avl_waitrequest_n = 1'($urandom);
        end

        avl_readdatavalid = 1'b0;
        if (pending > 0 && !(beat_stall && bidx >= 1) && $urandom_range(0, 1) == 1) begin
          avl_readdatavalid = 1'b1;
          avl_readdata = ddr_rd(int'(rbase) + bidx);
          bidx++;
          pending--;
          if (pending == 0) last_beat_cyc = cyc_cnt;
        end else if (pending == 0 && !avl_read && $urandom_range(0, 7) == 0) begin
          avl_readdatavalid = 1'b1;
          avl_readdata = $urandom;
        end

        if (cpu_ready) begin
          chk("ready_single_cycle", prev_ready, 0);
          if (exp_q.size() == 0) begin
            chk("spurious_ready", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", cpu_rdata, e.rdata);
            chk("cmd_count", cmd_log.size(), e.n_cmd);
            if (e.n_cmd == 1 && cmd_log.size() == 1) begin
              c = cmd_log[0];
              chk("cmd_kind", c.is_wr, e.is_wr);
              chk("cmd_addr", c.addr, e.addr);
              chk("cmd_burstcount", c.bc, e.bc);
              if (e.is_wr) begin
                chk("cmd_byteenable", c.be, e.be);
                chk("cmd_writedata", c.wdata, e.wdata);
              end else begin
                chk("fill_to_ready", cyc_cnt, last_beat_cyc + 1);
              end
              if (e.held > 0) chk("cmd_held_cycles", c.held, e.held);
            end
          end
          cmd_log.delete();
        end
        prev_ready = cpu_ready;
        init_prev  = init_done;
      end
    end
  end

  // One CPU request: predict with the memory model, drive, wait for ready.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                        input int fmode, input bit init_hold, input int wn);
    exp_t        e;
    logic [20:0] wa, tag;
    bit          hit;
    int          cyc;
    int          fm;
    fm  = fmode;
    wa  = addr[22:2];
    tag = wa & ~21'(BURST_LEN - 1);
    hit = 0;
    e.held = (wn >= 0) ? wn + 1 : 0;
    if (strb == 4'h0) begin
      hit = m_valid && (m_tag == tag) && (fm != 1);
      e.is_wr = 0; e.rdata = ref_rd(int'(wa)); e.n_cmd = hit ? 0 : 1;
      e.addr = tag; e.bc = 3'(BURST_LEN); e.be = 4'h0; e.wdata = '0;
      if (hit) fm = 0;
      else begin
        m_tag   = tag;
        m_valid = (fm != 2);
      end
    end else begin
      e.is_wr = 1; e.rdata = '0; e.n_cmd = 1; e.addr = wa; e.bc = 3'd1;
      e.be = strb; e.wdata = wdata;
      ref_mem[int'(wa)] = merge(ref_rd(int'(wa)), wdata, strb);
      if (fm == 1) m_valid = 0;
      fm = 0;
    end
    exp_q.push_back(e);
    wait_n = wn;
    @(posedge clk_clk); #1;
    if (init_hold) init_done = 1'b0;
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = strb;
    flush = (fm == 1);
    cyc = 0;
    while (1) begin
      @(posedge clk_clk); #1;
      cyc++;
      flush = (fm == 2 && cyc == 1);
      if (init_hold && cyc == 10) init_done = 1'b1;
      if (init_hold && cyc == 11) chk("init_release_cmd", avl_read | avl_write, 1);
      if (cpu_ready || cyc >= 300) break;
    end
    if (!cpu_ready) chk("req_timeout", cpu_ready, 1);
    else if (hit) chk("hit_latency", cyc, 1);
    cpu_valid = 1'b0; flush = 1'b0; cpu_wstrb = '0;
    wait_n = -1;
  endtask

  // Start a miss fill, stop the beats after the first one, then reset.
  task automatic reset_mid_fill(input logic [31:0] addr);
    int cyc;
    beat_stall = 1;
    @(posedge clk_clk); #1;
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wstrb = '0;
    cyc = 0;
    while (!(bidx >= 1 && pending > 0) && cyc < 200) begin
      @(posedge clk_clk); #1;
      cyc++;
    end
    chk("fill_started", (bidx >= 1 && pending > 0), 1);
    reset_reset = 1'b1; cpu_valid = 1'b0;
    #1;
    chk("rst_mid_ctrl", {cpu_ready, avl_beginbursttransfer, avl_read, avl_write, avl_burstcount, avl_byteenable}, 0);
    chk("rst_mid_addr", avl_address, 0);
    chk("rst_mid_rdata", cpu_rdata, 0);
    exp_q.delete();
    m_valid = 0;
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    beat_stall = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached with %0d expected responses pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [3:0]  s;
    int          r, fm;
    reset_reset = 1'b1; init_done = 1'b1; flush = 1'b0; cpu_valid = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_ctrl", {cpu_ready, avl_beginbursttransfer, avl_read, avl_write, avl_burstcount, avl_byteenable}, 0);
    chk("rst_addr", avl_address, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_wdata", avl_writedata, 0);
    reset_reset = 1'b0;

    do_req(32'h0000_0014, '0, 4'h0, 0, 0, -1);
    do_req(32'h0000_0018, '0, 4'h0, 0, 0, -1);
    do_req(32'h0000_0014, 32'hAABB_CCDD, 4'b0011, 0, 0, 3);
    do_req(32'h0000_0014, '0, 4'h0, 0, 0, -1);
    do_req(32'h0000_0100, '0, 4'h0, 0, 1, -1);
    do_req(32'h0000_0200, '0, 4'h0, 2, 0, -1);
    do_req(32'h0000_0200, '0, 4'h0, 0, 0, -1);
    do_req(32'h0000_0204, '0, 4'h0, 1, 0, -1);
    do_req(32'hFF80_0208, '0, 4'h0, 0, 0, -1);
    reset_mid_fill(32'h0000_0300);
    do_req(32'h0000_0300, '0, 4'h0, 0, 0, -1);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[22:2] = 21'($urandom);
      else a[22:2] = 21'($urandom_range(0, 31));
      s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_req(a, $urandom, s, fm, 0, -1);
    end

    repeat (4) @(posedge clk_clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/picorv32_avl_line_bridge.md
Name: picorv32_avl_line_bridge

Overview:
- Bridges the PicoRV32 native memory port (valid/ready) to the DDR3 EMIF Avalon-MM burst slave.
- Successor to the fixed-width single-beat hookup: parametrised address width and burst length.
- Adds a one-line read buffer that is filled by a full Avalon burst and serves later hits in one cycle.
- Writes are write-through and single-beat. Sits between the CPU memory mux and the controller's avl_* port.

Parameters:
- ADDR_W, 21, Avalon word-address width. Words are 32-bit.
- BURST_LEN, 4, words per line fill. Power of 2, range 2..2^(BURST_W-1).
- BURST_W, 3, width of avl_burstcount.

Ports:
- clk_clk  in  1  single clock; also the controller's afi clock.
- reset_reset  in  1  asynchronous, active-high reset.
- init_done  in  1  controller local_init_done. While low, no Avalon command is issued.
- flush  in  1  single-cycle pulse; invalidates the line buffer.
- cpu_valid  in  1  CPU request; held high until cpu_ready.
- cpu_addr  in  32  byte address. Bits [1:0] ignored; bits above ADDR_W+1 ignored (aliasing).
- cpu_wdata  in  32  write data.
- cpu_wstrb  in  4  byte strobes. 0 means read.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data; valid when cpu_ready is high.
- avl_address  out  ADDR_W  Avalon word address.
- avl_burstcount  out  BURST_W  1 for writes, BURST_LEN for reads.
- avl_beginbursttransfer  out  1  pulses on the first command cycle of each transaction.
- avl_read  out  1  read command.
- avl_write  out  1  write command.
- avl_writedata  out  32  write data.
- avl_byteenable  out  4  byte enables (equal to cpu_wstrb).
- avl_waitrequest_n  in  1  command accepted when high.
- avl_readdata  in  32  read data.
- avl_readdatavalid  in  1  read beat valid.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; line_valid 0; beat counter 0.
  - Asynchronous reset mid-transaction abandons it. The controller is reset by the same source.
- Derived values:
  - Word address wa = cpu_addr[ADDR_W+1:2].
  - Line tag = wa with the low log2(BURST_LEN) bits cleared.
  - Offset = wa low bits.
- IDLE:
  - Read hit (cpu_valid, wstrb==0, line_valid, tag match): cpu_ready and cpu_rdata = buf[offset] on the next cycle. No Avalon traffic. Latency 1.
  - Read miss with init_done=1: go to RD_CMD. Drive avl_read=1, avl_address=tag, burstcount=BURST_LEN, beginbursttransfer=1 for the first cycle only.
  - Write (wstrb!=0) with init_done=1: go to WR. Drive avl_write=1, address=wa, burstcount=1, writedata, byteenable=wstrb, beginbursttransfer on the first cycle.
  - If the write hits the line, update the buffer bytes selected by wstrb in the same cycle it enters WR.
  - With init_done=0, the request stalls in IDLE.
- WR: hold all command outputs stable until the cycle avl_waitrequest_n=1. Then deassert avl_write, go to RESP.
- RD_CMD: hold the command until avl_waitrequest_n=1, then go to RD_DATA.
  - Read beats may arrive in the acceptance cycle or later; they are counted in both RD_CMD and RD_DATA.
- RD_DATA:
  - Each avl_readdatavalid writes buf[beat] and increments beat.
  - On beat BURST_LEN-1: set tag, set line_valid=1, go to RESP.
- RESP: cpu_ready=1 for one cycle, then go to IDLE.
  - Reads return buf[offset]; writes return cpu_rdata=0.
  - Next request is accepted at the earliest the cycle after the cpu_ready pulse.
- Flush:
  - In IDLE, flush clears line_valid next cycle. Flush wins over a same-cycle hit: that request is treated as a miss.
  - During a fill, flush is latched. The fill completes and the CPU receives data, but line_valid ends at 0.
- Beat counter wraps to 0 after BURST_LEN-1. Stray readdatavalid in IDLE/WR is ignored.
- Only one outstanding Avalon transaction at any time.

Decomposition:
- Package picorv32_avl_pkg holds:
  - state enum (IDLE, WR, RD_CMD, RD_DATA, RESP);
  - OFF_W = $clog2(BURST_LEN);
  - the burstcount/word constants.
- One sub-module, avl_line_buf: BURST_LEN x 32 register array with a byte-strobed write port and a combinational read port. No reset on data.

Test Plan:
- Read miss at cpu_addr 0x0000_0014, BURST_LEN=4 -> one avl_read, address 0x4, burstcount 4, beginbursttransfer for 1 cycle. Beats D0..D3 fill the buffer; cpu_rdata=D1, cpu_ready 1 cycle after beat 3.
- Follow-up read at 0x0000_0018 -> cpu_ready next cycle, rdata=D2, no avl_read.
- Write 0x0000_0014, wdata 0xAABBCCDD, wstrb 0b0011, waitrequest_n low 3 cycles -> command held stable 4 cycles, byteenable 0x3. Following read of 0x14 hits with low half 0xCCDD and upper half from D1.
- init_done=0 with cpu_valid held 10 cycles -> no avl_read/avl_write. Once init_done=1, command starts next cycle.
- Flush asserted during RD_DATA beat 1 -> CPU receives data. A repeat read of the same address misses and issues a new burst.
- reset_reset asserted mid-RD_DATA -> all outputs 0 immediately, line_valid 0. A post-reset read issues a fresh burst.
